// File: rtl/alu_flags_stage.sv
// Execute stage after the barrel shifter: ARM condition check against the NZCV register,
// the 16 data-processing opcodes, and a one-deep registered result with valid/ready.
module alu_flags_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        set_flags,
  input  logic [3:0]  rd_addr,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        shift_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  rd_out,
  output logic        wr_en,
  output logic [3:0]  flags
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              carry;
    logic              ovf;
    logic              arith;
  } alu_res_t;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v;
    logic pass;
    {n, z, cf, v} = nzcv;
    unique case (c)
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = cf;
      4'h3:    pass = !cf;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = cf && !z;
      4'h9:    pass = !cf || z;
      4'hA:    pass = (n == v);
      4'hB:    pass = (n != v);
      4'hC:    pass = !z && (n == v);
      4'hD:    pass = z || (n != v);
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Every arithmetic opcode is x + y + cin on one 33-bit adder; the operand swap and
  // inversion select which of the eight forms is computed.
  function automatic alu_res_t alu_eval(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b, input logic c_in,
                                        input logic sc);
    alu_res_t          r;
    logic signed [DATA_W-1:0] x, y;
    logic              cin;
    logic [DATA_W:0]   sum;
    r       = '0;
    r.arith = 1'b1;
    x       = a;
    y       = b;
    cin     = 1'b0;
    unique case (op)
      OP_SUB, OP_CMP: begin x = a; y = ~b; cin = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
      OP_ADD, OP_CMN: begin x = a; y = b;  cin = 1'b0; end
      OP_ADC:         begin x = a; y = b;  cin = c_in; end
      OP_SBC:         begin x = a; y = ~b; cin = c_in; end
      OP_RSC:         begin x = b; y = ~a; cin = c_in; end
      default:        r.arith = 1'b0;
    endcase
    sum   = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
    r.ovf = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
    r.carry = r.arith ? sum[DATA_W] : sc;
    unique case (op)
      OP_AND, OP_TST: r.res = a & b;
      OP_EOR, OP_TEQ: r.res = a ^ b;
      OP_ORR:         r.res = a | b;
      OP_MOV:         r.res = b;
      OP_BIC:         r.res = a & ~b;
      OP_MVN:         r.res = ~b;
      default:        r.res = sum[DATA_W-1:0];
    endcase
    return r;
  endfunction

  // Stage p0: combinational evaluation of the presented instruction
  alu_res_t          alu_p0;
  logic              pass_p0;
  logic              accept_p0;
  logic              writes_p0;
  logic [3:0]        nzcv_next_p0;

  // Stage p1: registered result and architectural flags
  logic              vld_p1;
  logic [DATA_W-1:0] result_p1;
  logic [3:0]        rd_p1;
  logic              wr_en_p1;
  logic [3:0]        nzcv_p1;

  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;

  always_comb begin
    alu_p0    = alu_eval(opcode, op_a, op_b, nzcv_p1[1], shift_carry);
    pass_p0   = cond_pass(cond, nzcv_p1);
    // Compare/test opcodes (10xx) only ever touch the flags.
    writes_p0 = pass_p0 && (opcode[3:2] != 2'b10);
    nzcv_next_p0 = {alu_p0.res[DATA_W-1],
                    (alu_p0.res == '0),
                    alu_p0.carry,
                    alu_p0.arith ? alu_p0.ovf : nzcv_p1[0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      rd_p1     <= '0;
      wr_en_p1  <= 1'b0;
      nzcv_p1   <= '0;
    end else if (accept_p0) begin
      vld_p1    <= 1'b1;
      result_p1 <= alu_p0.res;
      rd_p1     <= rd_addr;
      wr_en_p1  <= writes_p0;
      if (pass_p0 && set_flags) begin
        nzcv_p1 <= nzcv_next_p0;
      end
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign result    = result_p1;
  assign rd_out    = rd_p1;
  assign wr_en     = wr_en_p1;
  assign flags     = nzcv_p1;

endmodule

// File: tb/tb_alu_flags_stage.sv
// Directed bench for alu_flags_stage: a reference model built from plain integer
// arithmetic is compared every cycle, plus hand-computed checkpoints.
module tb_alu_flags_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        set_flags;
  logic [3:0]  rd_addr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        shift_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  rd_out;
  logic        wr_en;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;
  int lit_id = 0;
  int dret;

  always #5 clk = ~clk;

  alu_flags_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .opcode(opcode), .set_flags(set_flags), .rd_addr(rd_addr),
    .op_a(op_a), .op_b(op_b), .shift_carry(shift_carry),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_out(rd_out), .wr_en(wr_en), .flags(flags)
  );

  // Reference model: condition table and integer-arithmetic ALU.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {result, carry, overflow, is_arith}.
  function automatic logic [34:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cf,
                                            input logic sc);
    longint ua, ub, sa, sb, us, ss, ci;
    logic [31:0] r;
    logic c, v, ar, is_add;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = cf ? 64'sd1 : 64'sd0;
    us = 0; ss = 0; r = 32'd0; c = sc; v = 1'b0; ar = 1'b1; is_add = 1'b0;
    case (op)
      4'h4, 4'hB: begin us = ua + ub;      ss = sa + sb;      is_add = 1'b1; end
      4'h5:       begin us = ua + ub + ci; ss = sa + sb + ci; is_add = 1'b1; end
      4'h2, 4'hA: begin us = ua - ub;            ss = sa - sb;            end
      4'h6:       begin us = ua - ub - (1 - ci); ss = sa - sb - (1 - ci); end
      4'h3:       begin us = ub - ua;            ss = sb - sa;            end
      4'h7:       begin us = ub - ua - (1 - ci); ss = sb - sa - (1 - ci); end
      4'h0, 4'h8: begin ar = 1'b0; r = a & b;  end
      4'h1, 4'h9: begin ar = 1'b0; r = a ^ b;  end
      4'hC:       begin ar = 1'b0; r = a | b;  end
      4'hD:       begin ar = 1'b0; r = b;      end
      4'hE:       begin ar = 1'b0; r = a & ~b; end
      default:    begin ar = 1'b0; r = ~b;     end
    endcase
    if (ar) begin
      r = us[31:0];
      c = is_add ? (us >= 64'sd4294967296) : (us >= 64'sd0);
      v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end
    return {r, c, v, ar};
  endfunction

  logic        mvld, mwr;
  logic [31:0] mres;
  logic [3:0]  mrd, mflags;
  int          macc;
  logic        m_acc, m_pass, m_writes;
  logic [34:0] m_alu;
  logic [31:0] m_res;

  always_comb begin
    m_acc    = in_valid && (!mvld || out_ready) && !reset;
    m_pass   = model_cond(cond, mflags);
    m_alu    = model_alu(opcode, op_a, op_b, mflags[1], shift_carry);
    m_res    = m_alu[34:3];
    m_writes = m_pass && !(opcode inside {4'h8, 4'h9, 4'hA, 4'hB});
  end

  always @(posedge clk) begin
    if (reset) begin
      mvld <= 1'b0; mres <= 32'd0; mrd <= 4'd0; mwr <= 1'b0; mflags <= 4'd0; macc <= 0;
    end else if (m_acc) begin
      mvld <= 1'b1;
      mres <= m_res;
      mrd  <= rd_addr;
      mwr  <= m_writes;
      macc <= macc + 1;
      if (m_pass && set_flags)
        mflags <= {m_res[31], (m_res == 32'd0), m_alu[2], m_alu[0] ? m_alu[1] : mflags[0]};
    end else if (out_ready) begin
      mvld <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare process: model every cycle, literal checkpoints when lit_id selects one.
  initial begin
    dret = 0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) dret++;
      chk("out_valid", 32'(out_valid), 32'(mvld));
      chk("in_ready",  32'(in_ready),  32'(!mvld || out_ready));
      chk("result",    result,         mres);
      chk("rd_out",    32'(rd_out),    32'(mrd));
      chk("wr_en",     32'(wr_en),     32'(mwr));
      chk("flags",     32'(flags),     32'(mflags));
      case (lit_id)
        1:  begin chk("rst_vld", 32'(out_valid), 0); chk("rst_wr", 32'(wr_en), 0);
                  chk("rst_flags", 32'(flags), 0);   chk("rst_res", result, 0); end
        2:  begin chk("adds_res", result, 32'h80000000); chk("adds_wr", 32'(wr_en), 1);
                  chk("adds_flags", 32'(flags), 32'h9); chk("adds_rd", 32'(rd_out), 1); end
        3:  begin chk("cmp_flags", 32'(flags), 32'h6); chk("cmp_wr", 32'(wr_en), 0); end
        4:  begin chk("moveq_res", result, 32'h12); chk("moveq_wr", 32'(wr_en), 1); end
        5:  begin chk("movne_res", result, 32'h34); chk("movne_wr", 32'(wr_en), 0);
                  chk("movne_flags", 32'(flags), 32'h6); end
        6:  begin chk("addsz_res", result, 0); chk("addsz_flags", 32'(flags), 32'h6); end
        7:  begin chk("adc_res", result, 3); chk("adc_wr", 32'(wr_en), 1); end
        8:  begin chk("subs_res", result, 32'hFFFFFFFF); chk("subs_flags", 32'(flags), 32'h8); end
        9:  chk("preload_flags", 32'(flags), 32'h9);
        10: begin chk("ands_res", result, 0); chk("ands_flags", 32'(flags), 32'h7); end
        11: begin chk("tst_wr", 32'(wr_en), 0); chk("tst_flags", 32'(flags), 32'h9); end
        12: begin chk("stall_rdy", 32'(in_ready), 0); chk("stall_vld", 32'(out_valid), 1);
                  chk("stall_res", result, 32'h30); chk("stall_flags", 32'(flags), 0);
                  chk("stall_rd", 32'(rd_out), 11); end
        13: begin chk("rel_res", result, 2); chk("rel_rd", 32'(rd_out), 12);
                  chk("rel_flags", 32'(flags), 32'h2); end
        14: begin chk("cmpv_res", result, 32'h7FFFFFFF); chk("cmpv_flags", 32'(flags), 32'h3); end
        15: begin chk("sbc_res", result, 0); chk("sbc_flags", 32'(flags), 32'h6); end
        16: begin chk("rsc_res", result, 32'hFFFFFFFF); chk("rsc_flags", 32'(flags), 32'h8); end
        17: begin chk("movlt_res", result, 32'h77); chk("movlt_wr", 32'(wr_en), 1); end
        18: begin chk("movge_res", result, 32'h88); chk("movge_wr", 32'(wr_en), 0); end
        19: begin chk("movnv_wr", 32'(wr_en), 0); chk("movnv_flags", 32'(flags), 32'h8); end
        99: begin chk("retired", 32'(dret), 32'(macc)); chk("drained", 32'(out_valid), 0); end
        default: ;
      endcase
    end
  end

  task automatic set_op(input logic [3:0] c, input logic [3:0] op, input logic s,
                        input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic sc);
    in_valid = 1'b1; cond = c; opcode = op; set_flags = s; rd_addr = rd;
    op_a = a; op_b = b; shift_carry = sc;
  endtask

  task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic s,
                       input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input int lit);
    @(posedge clk); #1;
    lit_id = lit;
    set_op(c, op, s, rd, a, b, sc);
  endtask

  task automatic idle(input int lit);
    @(posedge clk); #1;
    lit_id = lit;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    set_op(4'hE, 4'h4, 1'b1, 4'd15, 32'd1, 32'd1, 1'b0);
    @(posedge clk); #1; lit_id = 1;
    @(posedge clk); #1; lit_id = 1;
    reset = 1'b0;
    set_op(4'hE, 4'h4, 1'b1, 4'd1, 32'h7FFFFFFF, 32'd1, 1'b0);        // ADDS
    issue(4'hE, 4'hA, 1'b1, 4'd2, 32'd5, 32'd5, 1'b0, 2);              // CMP
    issue(4'h0, 4'hD, 1'b0, 4'd3, 32'd0, 32'h12, 1'b0, 3);             // MOVEQ
    issue(4'h1, 4'hD, 1'b0, 4'd4, 32'd0, 32'h34, 1'b0, 4);             // MOVNE
    issue(4'hE, 4'h4, 1'b1, 4'd5, 32'hFFFFFFFF, 32'd1, 1'b0, 5);       // ADDS -> 0
    issue(4'hE, 4'h5, 1'b0, 4'd6, 32'd1, 32'd1, 1'b0, 6);              // ADC
    issue(4'hE, 4'h2, 1'b1, 4'd7, 32'd0, 32'd1, 1'b0, 7);              // SUBS
    issue(4'hE, 4'h4, 1'b1, 4'd8, 32'h7FFFFFFF, 32'd1, 1'b0, 8);       // preload V
    issue(4'hE, 4'h0, 1'b1, 4'd9, 32'hF0, 32'h0F, 1'b1, 9);            // ANDS
    issue(4'hE, 4'h8, 1'b1, 4'd10, 32'h80000000, 32'h80000001, 1'b0, 10); // TST
    issue(4'hE, 4'h4, 1'b1, 4'd11, 32'h10, 32'h20, 1'b0, 11);          // ADDS then stall
    @(posedge clk); #1; lit_id = 12; out_ready = 1'b0;
    set_op(4'hE, 4'h2, 1'b1, 4'd12, 32'd5, 32'd3, 1'b0);
    @(posedge clk); #1; lit_id = 12;
    @(posedge clk); #1; lit_id = 12;
    @(posedge clk); #1; lit_id = 0; out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      issue(4'(i % 16), 4'((i * 5 + 3) % 16), (i % 3) != 0, 4'(i),
            32'h9E3779B9 * (i + 1), ((i % 2) != 0 ? 32'h80000000 : 32'h0) ^ (32'h01010101 * i),
            i[1], (i == 0) ? 13 : 0);
      if (i == 10) begin
        @(posedge clk); #1; lit_id = 0; out_ready = 1'b0;
        @(posedge clk); #1; out_ready = 1'b1;
      end
    end
    issue(4'hE, 4'hA, 1'b1, 4'd0, 32'h80000000, 32'd1, 1'b0, 0);       // CMP overflow
    issue(4'hE, 4'h6, 1'b1, 4'd1, 32'd5, 32'd5, 1'b0, 14);             // SBCS
    issue(4'hE, 4'h7, 1'b1, 4'd2, 32'd1, 32'd0, 1'b0, 15);             // RSCS
    issue(4'hB, 4'hD, 1'b0, 4'd5, 32'd0, 32'h77, 1'b0, 16);            // MOVLT
    issue(4'hA, 4'hD, 1'b0, 4'd6, 32'd0, 32'h88, 1'b0, 17);            // MOVGE
    issue(4'hF, 4'hD, 1'b1, 4'd7, 32'd0, 32'd0, 1'b1, 18);             // never
    idle(19);
    idle(0);
    idle(0);
    @(posedge clk); #1; lit_id = 99;
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
